piso_seq_ctrl: RTL and testbench

- Sequencer for the 16-bit parallel-in/serial-out rotate register.
- Replaces the register's derived slow clock with single-cycle load/shift enable strobes on the system clock.
- Detects the save-button edge, issues one load strobe, then issues timed shift strobes in one of two modes:
  - fixed-count burst
  - continuous rotate until stopped
- Sits between the button/switch inputs and the rotate register; the register consumes load_en/shift_en as clock enables.

---
 rtl/piso_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_piso_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_seq_ctrl.sv
// piso_seq_ctrl: sequencer for the 16-bit parallel-in/serial-out rotate register.
// Detects a rising edge on start, issues one load strobe, then timed shift strobes
// either for a fixed count or continuously until stop. All strobes are single
// system-clock cycles and are meant to be used as clock enables by the register.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        save-button level (already synchronised); rising edge starts a sequence
//   stop         level; aborts an active sequence and blocks start while high
//   mode         0 = continuous rotate, 1 = fixed count
//   shift_cnt    shift count for fixed mode, latched on the accepted start edge
//   load_en      one-cycle load strobe
//   shift_en     one-cycle rotate-left strobe
//   busy         high from the load_en cycle through the last shift_en cycle
//   done         one-cycle pulse when a fixed-count sequence completes
//   shifts_done  shifts issued in the current or last sequence
module piso_seq_ctrl #(
    parameter int unsigned TICK_PERIOD = 67108864,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic             load_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shifts_done
);

    localparam int unsigned TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    // Shift is decided one cycle ahead so the registered strobe lands on L+P, L+2P, ...
    localparam logic [TICK_W-1:0] TICK_FIRE = TICK_W'(TICK_PERIOD - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TICK_W-1:0]  tick;

    logic               start_edge;
    logic               accept;
    logic               mode_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [TICK_W-1:0]  tick_nxt;
    logic               load_nxt;
    logic               shift_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [CNT_W-1:0]   shifts_done_nxt;

    assign start_edge = start && !start_q;
    assign accept     = (state == IDLE) && start_edge && !stop;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            tick        <= '0;
            load_en     <= 1'b0;
            shift_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shifts_done <= '0;
        end else begin
            state       <= state_nxt;
            start_q     <= start;
            mode_q      <= mode_nxt;
            cnt_q       <= cnt_nxt;
            tick        <= tick_nxt;
            load_en     <= load_nxt;
            shift_en    <= shift_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            shifts_done <= shifts_done_nxt;
        end
    end

    // Next-state logic; stop always wins over completion or a due tick
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (mode_q && (cnt_q == '0)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // shift_en/shifts_done here are the strobe just issued and its updated count
                if (stop) begin
                    state_nxt = IDLE;
                end else if (mode_q && shift_en && (shifts_done == cnt_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        mode_nxt        = mode_q;
        cnt_nxt         = cnt_q;
        tick_nxt        = '0;
        shift_nxt       = 1'b0;
        shifts_done_nxt = shifts_done;

        load_nxt = (state_nxt == LOAD);
        busy_nxt = (state_nxt == LOAD) || (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);

        if (accept) begin
            mode_nxt        = mode;
            cnt_nxt         = shift_cnt;
            shifts_done_nxt = '0;
        end

        if (state == RUN) begin
            tick_nxt  = (tick == TICK_LAST) ? '0 : tick + TICK_W'(1);
            shift_nxt = (tick == TICK_FIRE) && !stop;
        end

        if (shift_nxt) begin
            shifts_done_nxt = shifts_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Testbench for piso_seq_ctrl with TICK_PERIOD=4: a per-cycle vector table for the
// fixed-count sequences plus directed sequences for continuous/stop, start
// retrigger, start+stop collision and mid-run reset.
module tb_piso_seq_ctrl;

    localparam int unsigned P     = 4;
    localparam int unsigned CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] shift_cnt;
    logic             load_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shifts_done;

    int checks   = 0;
    int failures = 0;

    piso_seq_ctrl #(
        .TICK_PERIOD(P),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .shift_cnt  (shift_cnt),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done),
        .shifts_done(shifts_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             start;
        logic             stop;
        logic             mode;
        logic [CNT_W-1:0] cnt;
        logic             ld;
        logic             sh;
        logic             bz;
        logic             dn;
        logic [CNT_W-1:0] sd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic s, input logic p, input logic m,
                                input int c, input logic ld, input logic sh, input logic bz,
                                input logic dn, input int sd);
        vec_t v;
        v.rst_n = r;  v.start = s;  v.stop = p;  v.mode = m;  v.cnt = CNT_W'(c);
        v.ld = ld;    v.sh = sh;    v.bz = bz;   v.dn = dn;   v.sd = CNT_W'(sd);
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: inputs set before the edge, outputs sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int loads;
    int dones;
    int nsh;
    int waited;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; shift_cnt = '0;

        // rst start stop mode cnt | ld sh bz dn sd
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);   // reset
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 3,  1, 0, 1, 0, 0);   // L: load strobe, fixed count 3
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 0);   // mode/cnt changes ignored from here on
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 7,  0, 1, 1, 0, 1);   // L+4
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 1);
        add(1, 1, 0, 0, 7,  0, 1, 1, 0, 2);   // L+8
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 2);
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 2);
        add(1, 1, 0, 0, 7,  0, 0, 1, 0, 2);
        add(1, 1, 0, 0, 7,  0, 1, 1, 0, 3);   // L+12, last shift, still busy
        add(1, 1, 0, 0, 7,  0, 0, 0, 1, 3);   // done
        add(1, 1, 0, 0, 7,  0, 0, 0, 0, 3);   // held start does not retrigger
        add(1, 0, 0, 1, 0,  0, 0, 0, 0, 3);
        add(1, 1, 0, 1, 0,  1, 0, 1, 0, 0);   // fixed count 0
        add(1, 0, 0, 1, 0,  0, 0, 0, 1, 0);   // done right after load
        add(1, 0, 0, 1, 0,  0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; start = tbl[i].start; stop = tbl[i].stop;
            mode = tbl[i].mode; shift_cnt = tbl[i].cnt;
            cyc();
            check($sformatf("vec%0d_load_en", i), 32'(load_en), 32'(tbl[i].ld));
            check($sformatf("vec%0d_shift_en", i), 32'(shift_en), 32'(tbl[i].sh));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].dn));
            check($sformatf("vec%0d_shifts_done", i), 32'(shifts_done), 32'(tbl[i].sd));
        end

        // Continuous rotate, stop on a cycle where a shift is due
        start = 1'b0; stop = 1'b0; mode = 1'b0; shift_cnt = CNT_W'(2);
        cyc();
        start = 1'b1;
        cyc();
        check("cont_load", 32'(load_en), 32'd1);
        nsh = 0;
        for (int n = 1; n <= 43; n++) begin
            cyc();
            check($sformatf("cont_shift_n%0d", n), 32'(shift_en), 32'((n % 4) == 0));
            check($sformatf("cont_done_n%0d", n), 32'(done), 32'd0);
            if (shift_en) nsh++;
        end
        check("cont_busy", 32'(busy), 32'd1);
        start = 1'b0; stop = 1'b1;
        cyc();
        check("cont_stop_shift", 32'(shift_en), 32'd0);
        check("cont_stop_busy", 32'(busy), 32'd0);
        check("cont_stop_done", 32'(done), 32'd0);
        check("cont_stop_sd", 32'(shifts_done), 32'd10);
        check("cont_strobes_seen", 32'(shifts_done), 32'(nsh));
        stop = 1'b0;
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            cyc();
            if (done || shift_en || busy) dones++;
        end
        check("cont_quiet_after_stop", 32'(dones), 32'd0);
        check("cont_sd_hold", 32'(shifts_done), 32'd10);

        // Start held through a completed sequence with an extra pulse while busy
        mode = 1'b1; shift_cnt = CNT_W'(2);
        loads = 0; dones = 0;
        for (int j = 0; j < 16; j++) begin
            start = (j < 2) || (j >= 4);
            cyc();
            if (load_en) loads++;
            if (done) dones++;
        end
        check("retrig_loads", 32'(loads), 32'd1);
        check("retrig_dones", 32'(dones), 32'd1);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        check("retrig_second_load", 32'(load_en), 32'd1);
        start = 1'b0;
        dones = 0;
        for (int j = 0; j < 20; j++) begin
            cyc();
            if (done) dones++;
        end
        check("retrig_second_done", 32'(dones), 32'd1);

        // start and stop rise together in IDLE
        start = 1'b1; stop = 1'b1;
        cyc();
        check("collide_load", 32'(load_en), 32'd0);
        check("collide_busy", 32'(busy), 32'd0);
        loads = 0;
        for (int j = 0; j < 6; j++) begin
            if (j == 3) stop = 1'b0;   // start still high: no new edge
            cyc();
            if (load_en || busy) loads++;
        end
        check("collide_no_start", 32'(loads), 32'd0);
        start = 1'b0;
        cyc();

        // Reset during RUN after two shifts
        mode = 1'b0; start = 1'b1;
        cyc();
        check("rst_load", 32'(load_en), 32'd1);
        start = 1'b0;
        waited = 0;
        while (shifts_done != CNT_W'(2) && waited < 20) begin
            cyc();
            waited++;
        end
        check("rst_two_shifts_seen", 32'(shifts_done == CNT_W'(2)), 32'd1);
        rst_n = 1'b0;
        cyc();
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_shifts_done", 32'(shifts_done), 32'd0);
        rst_n = 1'b1;
        loads = 0;
        for (int j = 0; j < 12; j++) begin
            cyc();
            if (load_en || shift_en || busy || done) loads++;
        end
        check("rst_quiet", 32'(loads), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
